// File: rtl/traffic_lights_cmd_gen_if.sv
// Host-request / command bus between a host, traffic_lights_cmd_gen and the traffic_lights block.
// Valid/ready: a request transfers on a rising clk_i edge where cfg_valid_i and cfg_ready_o are both 1.
interface traffic_lights_cmd_gen_if;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_mode_i;
  logic [15:0] green_i;
  logic [15:0] red_i;
  logic [15:0] yellow_i;
  logic [2:0]  cmd_type_o;
  logic        cmd_valid_o;
  logic [15:0] cmd_data_o;
  logic        busy_o;
  logic        err_o;
  logic [2:0]  dbg_state;

  modport master (
    output cfg_valid_i, cfg_mode_i, green_i, red_i, yellow_i,
    input  cfg_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o, err_o, dbg_state
  );

  modport slave (
    input  cfg_valid_i, cfg_mode_i, green_i, red_i, yellow_i,
    output cfg_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o, err_o, dbg_state
  );
endinterface

// File: rtl/traffic_lights_cmd_gen.sv
// Turns one host request into the OFF / SET_* / ON command sequence for the traffic_lights block.
// Optional duration/mode range check is enabled by defining TL_CMD_RANGE_CHECK_EN.
module traffic_lights_cmd_gen #(
  parameter int unsigned OFF_HOLD = 10,
  parameter int unsigned DUR_MAX  = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  traffic_lights_cmd_gen_if.slave  cfg
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OFF_HOLD = 3'd1,
    ST_SET_G    = 3'd2,
    ST_SET_R    = 3'd3,
    ST_SET_Y    = 3'd4,
    ST_ON       = 3'd5,
    ST_SINGLE   = 3'd6
  } state_e;

  localparam logic [1:0] MODE_LOAD_RUN = 2'd0;
  localparam logic [1:0] MODE_OFF      = 2'd1;
  localparam logic [1:0] MODE_BLINK    = 2'd2;

  localparam logic [2:0] CMD_ON        = 3'd0;
  localparam logic [2:0] CMD_OFF       = 3'd1;
  localparam logic [2:0] CMD_NOTRANS   = 3'd2;
  localparam logic [2:0] CMD_SET_GREEN = 3'd3;
  localparam logic [2:0] CMD_SET_RED   = 3'd4;
  localparam logic [2:0] CMD_SET_YEL   = 3'd5;

  // Last counter value of the OFF hold; OFF_HOLD=0 behaves as 1 and the 16-bit counter never wraps.
  localparam logic [15:0] HOLD_LAST =
    (OFF_HOLD <= 1)     ? 16'd0 :
    (OFF_HOLD > 65536)  ? 16'hFFFF :
                          16'(OFF_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  mode_q;
  logic [15:0] green_q, red_q, yellow_q;
  logic        single_cmd_q;
  logic        accept;
  logic        reject;

  assign accept = cfg.cfg_valid_i && (state_q == ST_IDLE);

`ifdef TL_CMD_RANGE_CHECK_EN
  logic err_q;

  assign reject = (cfg.cfg_mode_i == 2'd3) ||
                  ((cfg.cfg_mode_i == MODE_LOAD_RUN) &&
                   ((32'(cfg.green_i)  > DUR_MAX) ||
                    (32'(cfg.red_i)    > DUR_MAX) ||
                    (32'(cfg.yellow_i) > DUR_MAX)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= reject;
    end
  end

  assign cfg.err_o = (state_q == ST_SINGLE) && err_q;
`else
  logic dur_max_unused;

  assign reject         = 1'b0;
  assign dur_max_unused = (DUR_MAX == 0);
  assign cfg.err_o      = 1'b0;
`endif

  // Request fields are captured once at acceptance; the running sequence only sees these copies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q       <= MODE_LOAD_RUN;
      green_q      <= '0;
      red_q        <= '0;
      yellow_q     <= '0;
      single_cmd_q <= 1'b0;
    end else if (accept) begin
      mode_q       <= cfg.cfg_mode_i;
      green_q      <= cfg.green_i;
      red_q        <= cfg.red_i;
      yellow_q     <= cfg.yellow_i;
      single_cmd_q <= !reject &&
                      ((cfg.cfg_mode_i == MODE_OFF) || (cfg.cfg_mode_i == MODE_BLINK));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Zero durations skip their SET_* step, so each exit picks the next non-zero field.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hold_d = '0;
          if ((cfg.cfg_mode_i == MODE_LOAD_RUN) && !reject) begin
            state_d = ST_OFF_HOLD;
          end else begin
            state_d = ST_SINGLE;
          end
        end
      end
      ST_OFF_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (green_q != '0) begin
            state_d = ST_SET_G;
          end else if (red_q != '0) begin
            state_d = ST_SET_R;
          end else if (yellow_q != '0) begin
            state_d = ST_SET_Y;
          end else begin
            state_d = ST_ON;
          end
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      ST_SET_G: begin
        if (red_q != '0) begin
          state_d = ST_SET_R;
        end else if (yellow_q != '0) begin
          state_d = ST_SET_Y;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_SET_R: begin
        state_d = (yellow_q != '0) ? ST_SET_Y : ST_ON;
      end
      ST_SET_Y:  state_d = ST_ON;
      ST_ON:     state_d = ST_IDLE;
      ST_SINGLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so an asynchronous reset clears them immediately.
  always_comb begin
    cfg.cmd_valid_o = 1'b0;
    cfg.cmd_type_o  = CMD_ON;
    cfg.cmd_data_o  = '0;
    case (state_q)
      ST_OFF_HOLD: begin
        cfg.cmd_valid_o = 1'b1;
        cfg.cmd_type_o  = CMD_OFF;
      end
      ST_SET_G: begin
        cfg.cmd_valid_o = 1'b1;
        cfg.cmd_type_o  = CMD_SET_GREEN;
        cfg.cmd_data_o  = green_q;
      end
      ST_SET_R: begin
        cfg.cmd_valid_o = 1'b1;
        cfg.cmd_type_o  = CMD_SET_RED;
        cfg.cmd_data_o  = red_q;
      end
      ST_SET_Y: begin
        cfg.cmd_valid_o = 1'b1;
        cfg.cmd_type_o  = CMD_SET_YEL;
        cfg.cmd_data_o  = yellow_q;
      end
      ST_ON: begin
        cfg.cmd_valid_o = 1'b1;
        cfg.cmd_type_o  = CMD_ON;
      end
      ST_SINGLE: begin
        if (single_cmd_q) begin
          cfg.cmd_valid_o = 1'b1;
          cfg.cmd_type_o  = (mode_q == MODE_BLINK) ? CMD_NOTRANS : CMD_OFF;
        end
      end
      default: begin
        cfg.cmd_valid_o = 1'b0;
      end
    endcase
  end

  assign cfg.cfg_ready_o = (state_q == ST_IDLE);
  assign cfg.busy_o      = (state_q != ST_IDLE);
  assign cfg.dbg_state   = state_q;

endmodule

// File: doc/traffic_lights_cmd_gen.md
TRAFFIC_LIGHTS_CMD_GEN -- requirements
Module: traffic_lights_cmd_gen

Interface
REQ-001 Parameter OFF_HOLD, default 10: number of cycles the OFF command is held before a timing load.
REQ-002 Parameter DUR_MAX, default 1000: upper bound for durations, used only under TL_CMD_RANGE_CHECK_EN.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 cfg_valid_i  in  1  host request valid.
REQ-006 cfg_ready_o  out  1  block can accept a request.
REQ-007 cfg_mode_i  in  2  0=LOAD_RUN, 1=OFF, 2=BLINK, 3=reserved.
REQ-008 green_i / red_i / yellow_i  in  16 each  durations (ms) for LOAD_RUN.
REQ-009 cmd_type_o  out  3  0=ON, 1=OFF, 2=NOTRANSITION, 3=SET_GREEN, 4=SET_RED, 5=SET_YELLOW.
REQ-010 cmd_valid_o  out  1  command qualifier toward the traffic_lights block.
REQ-011 cmd_data_o  out  16  duration payload for SET_* commands.
REQ-012 busy_o  out  1  sequence in progress.
REQ-013 err_o  out  1  one-cycle pulse: request rejected.

Function
REQ-014 Handshake: request accepted on a cycle with cfg_valid_i=1 and cfg_ready_o=1; cfg_ready_o=1 only in IDLE; busy_o = not IDLE.
REQ-015 On acceptance, mode and all three durations are registered; later input changes do not affect the running sequence.
REQ-016 States: IDLE, OFF_HOLD, SET_G, SET_R, SET_Y, ON, SINGLE.
REQ-017 LOAD_RUN: IDLE -> OFF_HOLD (cmd_type 1, exactly OFF_HOLD cycles) -> SET_G (3, data=green, 1 cycle) -> SET_R (4, data=red, 1 cycle) -> SET_Y (5, data=yellow, 1 cycle) -> ON (0, 1 cycle) -> IDLE.
REQ-018 A registered duration of 0 skips its SET_* state (old value kept in the traffic_lights block); the sequence moves directly to the next state.
REQ-019 OFF request: SINGLE state, cmd_type 1 for 1 cycle, then IDLE; BLINK: same with cmd_type 2.
REQ-020 Reserved mode 3: accepted, no command issued, returns to IDLE on the next cycle.
REQ-021 First command cycle appears one cycle after acceptance; cmd_valid_o=1 in every non-IDLE state except after a mode-3 request; cmd_valid_o=0 in IDLE.
REQ-022 cmd_data_o = 0 whenever cmd_type_o is not SET_*; cmd_type_o = 0 in IDLE.
REQ-023 No back-pressure from the traffic_lights side; each command is consumed in the cycle it is valid.
REQ-024 OFF_HOLD counter is 16 bits, counts up from 0, and never wraps within a sequence; OFF_HOLD=0 is treated as 1.
REQ-025 Back-to-back requests: cfg_ready_o rises in the cycle after ON/SINGLE, so a new request can be accepted on that cycle with no idle gap beyond it.

Reset
REQ-026 With rst_ni low: state=IDLE, cfg_ready_o=1 after release, busy_o=0, cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, err_o=0, registered durations=0.
REQ-027 Reset asserted mid-sequence drops cmd_valid_o immediately, without waiting for a clock, and abandons the sequence; no partial resume occurs after release.

Configuration
REQ-028 Macro TL_CMD_RANGE_CHECK_EN defined: a LOAD_RUN request with any duration > DUR_MAX, or mode 3, is accepted but rejected: err_o=1 for 1 cycle, no commands issued, return to IDLE.
REQ-029 Macro undefined: no range check, err_o is tied to 0, and REQ-020 applies.

Verification
REQ-030 LOAD_RUN with g=50, r=30, y=20, OFF_HOLD=10 -> type 1 for 10 cycles, then 3/50, 4/30, 5/20, 0; total 14 valid cycles; busy_o high for those 14 cycles.
REQ-031 LOAD_RUN with g=0, r=40, y=0 -> 10 x type 1, then 4/40, then 0; no type 3 or 5 appears.
REQ-032 OFF request, then BLINK requested on the first ready cycle -> type 1 for one cycle, then type 2 for one cycle, with exactly one IDLE cycle between them.
REQ-033 rst_ni pulsed low during SET_R -> cmd_valid_o falls asynchronously; after release, cmd_valid_o stays 0 and cfg_ready_o=1.
REQ-034 With TL_CMD_RANGE_CHECK_EN and red=1001 -> err_o high for 1 cycle and cmd_valid_o stays 0; with the macro undefined, the same request produces the full sequence with 4/1001.
REQ-035 cfg_valid_i held high with durations changed mid-sequence -> issued data equals the values registered at acceptance.
